// File: rtl/pc_unit.sv
// pc_unit -- fetch-stage program counter.
//
// Holds the instruction-fetch address and picks the next PC at each rising
// clock edge. Highest priority first:
//   1. exception entry
//   2. return from exception
//   3. branch redirect
//   4. buffered redirect
//   5. sequential step
// A branch that arrives while fetch is stalled is stored, and it is applied
// on the first cycle the stall releases. All outputs are registered.
//
// Ports:
//   Clk        in   clock; all state updates on the rising edge
//   Reset      in   synchronous, active-low reset
//   En         in   advance enable; 0 = fetch stall, the PC holds
//   BrTaken    in   branch/jump redirect request from decode
//   BrTarget   in   [WIDTH] redirect target
//   Exc        in   exception flush request
//   Eret       in   return-from-exception request
//   Epc        in   [WIDTH] return address used by Eret
//   PC         out  [WIDTH] current fetch address
//   PcMisalign out  1 when the low ALIGN bits of PC are not zero
//   RedirPend  out  a buffered branch redirect is waiting
module pc_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int unsigned ALIGN     = 2,
    parameter int unsigned STEP      = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             BrTaken,
    input  logic [WIDTH-1:0] BrTarget,
    input  logic             Exc,
    input  logic             Eret,
    input  logic [WIDTH-1:0] Epc,
    output logic [WIDTH-1:0] PC,
    output logic             PcMisalign,
    output logic             RedirPend
);

    localparam logic [WIDTH-1:0] RST_PC   = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VEC);
    localparam logic [WIDTH-1:0] STEP_INC = WIDTH'(STEP);
    localparam logic             RST_MIS  = |RST_PC[ALIGN-1:0];

    logic [WIDTH-1:0] pc_q,    pc_d;
    logic [WIDTH-1:0] pend_q,  pend_d;
    logic             redir_q, redir_d;
    logic             mis_q,   mis_d;

    always_comb begin
        pc_d    = pc_q;
        pend_d  = pend_q;
        redir_d = redir_q;

        if (Exc) begin
            pc_d    = EXC_PC;
            redir_d = 1'b0;
        end else if (Eret) begin
            pc_d    = Epc;
            redir_d = 1'b0;
        end else if (BrTaken) begin
            if (En) begin
                pc_d    = BrTarget;
                redir_d = 1'b0;
            end else begin
                // The stall freezes the PC. Buffer the target, and let the
                // newest branch replace any older one.
                pend_d  = BrTarget;
                redir_d = 1'b1;
            end
        end else if (En) begin
            if (redir_q) begin
                pc_d    = pend_q;
                redir_d = 1'b0;
            end else begin
                pc_d = pc_q + STEP_INC;
            end
        end

        // The PC is loaded even when misaligned. The fault is only flagged.
        mis_d = |pc_d[ALIGN-1:0];
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q    <= RST_PC;
            pend_q  <= '0;
            redir_q <= 1'b0;
            mis_q   <= RST_MIS;
        end else begin
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            redir_q <= redir_d;
            mis_q   <= mis_d;
        end
    end

    assign PC         = pc_q;
    assign PcMisalign = mis_q;
    assign RedirPend  = redir_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised fetch-stage program counter: the successor to the plain PC register.
- Adds a prioritised next-PC select (exception, ERET, branch, sequential) and an alignment-fault flag.
- Buffers a branch redirect that arrives while fetch is stalled, and applies it when the stall releases.
- Sits in stage 1 (F): drives the instruction-memory address and the F/D PC pipeline register.

Parameters:
- WIDTH, 32, PC width in bits.
- RESET_VEC, 32'h0000_3000, PC value after reset (truncated to WIDTH).
- EXC_VEC, 32'h0000_4180, exception handler entry address.
- ALIGN, 2, number of low PC bits that must be zero (ALIGN >= 1).
- STEP, 4, sequential increment.

Ports:
- Clk  input  1  clock, all state updates on posedge.
- Reset  input  1  synchronous, active-low reset.
- En  input  1  advance enable; 0 = fetch stall, PC holds.
- BrTaken  input  1  branch/jump redirect request from D.
- BrTarget  input  WIDTH  redirect target.
- Exc  input  1  exception flush request from the exception unit.
- Eret  input  1  return-from-exception request.
- Epc  input  WIDTH  return address for Eret.
- PC  output  WIDTH  current fetch address (registered).
- PcMisalign  output  1  registered; 1 when PC[ALIGN-1:0] != 0.
- RedirPend  output  1  registered; a buffered branch redirect is waiting.

Behaviour:
- Reset and latency:
  - One clock; reset is synchronous and active-low. Reset==0 at posedge: PC=RESET_VEC, PcMisalign computed from RESET_VEC, RedirPend=0, pending target register=0.
  - Reset overrides every other input.
  - Latency: every input affects PC exactly one posedge later. No combinational input-to-output paths.
- Internal state: PC, PendAddr[WIDTH], RedirPend.
- Priority at each posedge with Reset==1, highest first:
  1. Exc: PC=EXC_VEC regardless of En; RedirPend=0.
  2. Eret: PC=Epc regardless of En; RedirPend=0.
  3. BrTaken && En: PC=BrTarget; RedirPend=0. A new branch supersedes any pending one.
  4. BrTaken && !En: PC holds; PendAddr=BrTarget; RedirPend=1. The latest branch overwrites any earlier pending target.
  5. !BrTaken && En && RedirPend: PC=PendAddr; RedirPend=0.
  6. !BrTaken && En && !RedirPend: PC=PC+STEP modulo 2^WIDTH. Wrap from all-ones region to low addresses is silent.
  7. !BrTaken && !En: PC and pending state hold.
- Exc and Eret asserted together: Exc wins.
- PcMisalign:
  - Updated in the same cycle as PC, from the new PC value.
  - The PC is loaded even when misaligned; the fault is reported, not suppressed. Fault handling belongs to the downstream exception logic.
  - A misaligned BrTarget or Epc is reported the same way.
- Pending redirect: PendAddr is don't-care when RedirPend=0, but it must not change except under case 4 or reset.
- Reset mid-stall with a pending redirect discards it: PC=RESET_VEC, RedirPend=0.

Test Plan:
- Reset and sequential step: hold Reset=0 two cycles, then release with En=1 for 3 cycles -> PC 0x3000, then 0x3004, 0x3008, 0x300C; PcMisalign=0; RedirPend=0.
- Stall then redirect: PC=0x3010, En=0; BrTaken=1, BrTarget=0x3100 for one cycle; hold En=0 two more cycles; then En=1.
  - PC stays 0x3010 throughout the stall; RedirPend=1.
  - First cycle with En=1: PC=0x3100, RedirPend=0.
  - Next cycle: PC=0x3104.
- Overwrite and supersede:
  - While stalled, branch to 0x3200, then to 0x3300 -> on release PC=0x3300.
  - Separately: pending 0x3200, then En=1 with BrTaken=1, BrTarget=0x3400 -> PC=0x3400, RedirPend=0.
- Exception priority:
  - En=0, RedirPend=1, Exc=1, Eret=1, BrTaken=1 -> PC=0x4180, RedirPend=0.
  - Next cycle Eret=1, Epc=0x3024 -> PC=0x3024.
- Misalign and wrap:
  - BrTarget=0x3102 with En=1 -> PC=0x3102, PcMisalign=1; next step PC=0x3106, PcMisalign=1.
  - Branch to 0xFFFF_FFFC then step -> PC=0x0000_0000, PcMisalign=0.
- Reset mid-operation: pending redirect plus En=0, assert Reset=0 -> PC=0x3000, RedirPend=0; after release with En=1, PC=0x3004 (pending target not applied).
